// File: rtl/lorenz_rk4_sequencer.sv
// RK4 step sequencer for a Lorenz integrator: drives an external derivative unit
// through four stage evaluations per step, then commits s += h/6*(k1+2k2+2k3+k4).
// Build option: define LORENZ_SAT_EN to saturate operand and state adds instead of wrapping.
module lorenz_rk4_sequencer #(
    parameter int                 H_SHIFT = 8,
    parameter logic signed [31:0] X0      = 32'sh00010000,
    parameter logic signed [31:0] Y0      = 32'sh00000000,
    parameter logic signed [31:0] Z0      = 32'sh00000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [15:0]        max_steps,
    input  logic               load,
    input  logic signed [31:0] init_x,
    input  logic signed [31:0] init_y,
    input  logic signed [31:0] init_z,
    output logic               deriv_req,
    output logic signed [31:0] deriv_x,
    output logic signed [31:0] deriv_y,
    output logic signed [31:0] deriv_z,
    input  logic               deriv_ack,
    input  logic signed [31:0] deriv_dx,
    input  logic signed [31:0] deriv_dy,
    input  logic signed [31:0] deriv_dz,
    output logic signed [31:0] x,
    output logic signed [31:0] y,
    output logic signed [31:0] z,
    output logic               out_valid,
    output logic               busy,
    output logic [15:0]        step_count
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_REQ1   = 4'd1;
    localparam logic [3:0] ST_REQ2   = 4'd2;
    localparam logic [3:0] ST_REQ3   = 4'd3;
    localparam logic [3:0] ST_REQ4   = 4'd4;
    localparam logic [3:0] ST_PREP1  = 4'd5;
    localparam logic [3:0] ST_PREP2  = 4'd6;
    localparam logic [3:0] ST_PREP3  = 4'd7;
    localparam logic [3:0] ST_PREP4  = 4'd8;
    localparam logic [3:0] ST_UPDATE = 4'd9;

    logic [3:0]  state_reg;
    logic [15:0] step_count_reg;
    logic        out_valid_reg;
    logic [1:0]  stage;
    logic        can_start;
    logic        can_continue;

    logic signed [31:0] init_v [3];
    logic signed [31:0] dd_v   [3];
    logic signed [31:0] s_v    [3];
    logic signed [31:0] op_v   [3];

`ifdef LORENZ_SAT_EN
    function automatic logic signed [31:0] sat32(input logic signed [35:0] v);
        if (v > 36'sd2147483647)
            return 32'sh7FFFFFFF;
        else if (v < -36'sd2147483648)
            return 32'sh80000000;
        else
            return v[31:0];
    endfunction
`endif

    assign init_v[0] = init_x;
    assign init_v[1] = init_y;
    assign init_v[2] = init_z;
    assign dd_v[0]   = deriv_dx;
    assign dd_v[1]   = deriv_dy;
    assign dd_v[2]   = deriv_dz;

    assign x          = s_v[0];
    assign y          = s_v[1];
    assign z          = s_v[2];
    assign deriv_x    = op_v[0];
    assign deriv_y    = op_v[1];
    assign deriv_z    = op_v[2];
    assign out_valid  = out_valid_reg;
    assign step_count = step_count_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign deriv_req  = (state_reg >= ST_REQ1) && (state_reg <= ST_REQ4);

    assign can_start    = (max_steps == 16'd0) || (step_count_reg < max_steps);
    assign can_continue = (max_steps == 16'd0) ||
                          (({1'b0, step_count_reg} + 17'd1) < {1'b0, max_steps});

    // Which previous slope feeds the operand currently on the request bus.
    always_comb begin
        stage = 2'd0;
        case (state_reg)
            ST_REQ2: stage = 2'd1;
            ST_REQ3: stage = 2'd2;
            ST_REQ4: stage = 2'd3;
            default: stage = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            step_count_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (load)
                        step_count_reg <= '0;
                    else if (run && can_start)
                        state_reg <= ST_REQ1;
                end
                ST_REQ1:  if (deriv_ack) state_reg <= ST_PREP1;
                ST_REQ2:  if (deriv_ack) state_reg <= ST_PREP2;
                ST_REQ3:  if (deriv_ack) state_reg <= ST_PREP3;
                ST_REQ4:  if (deriv_ack) state_reg <= ST_PREP4;
                ST_PREP1: state_reg <= ST_REQ2;
                ST_PREP2: state_reg <= ST_REQ3;
                ST_PREP3: state_reg <= ST_REQ4;
                ST_PREP4: state_reg <= ST_UPDATE;
                ST_UPDATE: begin
                    out_valid_reg  <= 1'b1;
                    step_count_reg <= step_count_reg + 16'd1;
                    state_reg      <= (run && can_continue) ? ST_REQ1 : ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            localparam logic signed [31:0] RST_V = (gi == 0) ? X0 : ((gi == 1) ? Y0 : Z0);

            logic signed [31:0] s_reg, k1_reg, k2_reg, k3_reg, k4_reg;
            logic signed [31:0] k_shift;
            logic signed [31:0] upd;
            logic signed [35:0] op_full;
            logic signed [34:0] sum;
            logic signed [34:0] sum_sh;
            logic signed [50:0] prod;
            logic signed [35:0] upd_full;
            logic               unused_frac;

            always_comb begin
                k_shift = '0;
                case (stage)
                    2'd1:    k_shift = k1_reg >>> (H_SHIFT + 1);
                    2'd2:    k_shift = k2_reg >>> (H_SHIFT + 1);
                    2'd3:    k_shift = k3_reg >>> H_SHIFT;
                    default: k_shift = '0;
                endcase
            end

            assign op_full = {{4{s_reg[31]}}, s_reg} + {{4{k_shift[31]}}, k_shift};

            // 10923/65536 approximates 1/6; the 51-bit product cannot overflow.
            assign sum      = {{3{k1_reg[31]}}, k1_reg} + {{2{k2_reg[31]}}, k2_reg, 1'b0}
                            + {{2{k3_reg[31]}}, k3_reg, 1'b0} + {{3{k4_reg[31]}}, k4_reg};
            assign sum_sh   = sum >>> H_SHIFT;
            assign prod     = {{16{sum_sh[34]}}, sum_sh} * 51'sd10923;
            assign upd_full = {{4{s_reg[31]}}, s_reg} + {prod[50], prod[50:16]};

`ifdef LORENZ_SAT_EN
            assign op_v[gi]    = sat32(op_full);
            assign upd         = sat32(upd_full);
            assign unused_frac = ^prod[15:0];
`else
            assign op_v[gi]    = op_full[31:0];
            assign upd         = upd_full[31:0];
            assign unused_frac = ^{prod[15:0], op_full[35:32], upd_full[35:32]};
`endif

            assign s_v[gi] = s_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_reg  <= RST_V;
                    k1_reg <= '0;
                    k2_reg <= '0;
                    k3_reg <= '0;
                    k4_reg <= '0;
                end else begin
                    if ((state_reg == ST_IDLE) && load)
                        s_reg <= init_v[gi];
                    else if (state_reg == ST_UPDATE)
                        s_reg <= upd;
                    if (deriv_ack) begin
                        case (state_reg)
                            ST_REQ1: k1_reg <= dd_v[gi];
                            ST_REQ2: k2_reg <= dd_v[gi];
                            ST_REQ3: k3_reg <= dd_v[gi];
                            ST_REQ4: k4_reg <= dd_v[gi];
                            default: ;
                        endcase
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_lorenz_rk4_sequencer.sv
// Self-checking bench for lorenz_rk4_sequencer: a behavioural derivative unit with
// programmable ack latency, plus a plain-arithmetic RK4 reference model.
module tb_lorenz_rk4_sequencer;
    localparam int H = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               run = 1'b0;
    logic [15:0]        max_steps = '0;
    logic               load = 1'b0;
    logic signed [31:0] init_x = '0, init_y = '0, init_z = '0;
    logic               deriv_req, deriv_ack;
    logic signed [31:0] deriv_x, deriv_y, deriv_z;
    logic signed [31:0] deriv_dx = '0, deriv_dy = '0, deriv_dz = '0;
    logic signed [31:0] x, y, z;
    logic               out_valid, busy;
    logic [15:0]        step_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    bit ack_tied = 0, ack_force = 0, ack_reg = 0, const_mode = 0;
    int ack_delay = 0, wait_cnt = 0, n_accept = 0;
    int c_d[3];
    int bias[3];
    int accept_q[$];
    logic signed [31:0] prev_op[3];
    int m_s[3];

    lorenz_rk4_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .max_steps(max_steps), .load(load),
        .init_x(init_x), .init_y(init_y), .init_z(init_z),
        .deriv_req(deriv_req), .deriv_x(deriv_x), .deriv_y(deriv_y), .deriv_z(deriv_z),
        .deriv_ack(deriv_ack), .deriv_dx(deriv_dx), .deriv_dy(deriv_dy), .deriv_dz(deriv_dz),
        .x(x), .y(y), .z(z), .out_valid(out_valid), .busy(busy), .step_count(step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign deriv_ack = ack_tied | ack_force | ack_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Derivative field used by both the responder and the reference model.
    function automatic void dfun(input int ox, input int oy, input int oz,
                                 output int dx, output int dy, output int dz);
        if (const_mode) begin
            dx = c_d[0]; dy = c_d[1]; dz = c_d[2];
        end else begin
            dx = ((oy - ox) <<< 3) + bias[0];
            dy = (ox >>> 2) - oy - (oz >>> 5) + bias[1];
            dz = ((ox >>> 4) ^ oy) - (oz >>> 3) + bias[2];
        end
    endfunction

    function automatic int fit(input longint v);
`ifdef LORENZ_SAT_EN
        if (v > 64'sd2147483647) return 32'sh7FFFFFFF;
        if (v < -64'sd2147483648) return 32'sh80000000;
`endif
        return int'(v);
    endfunction

    // One RK4 step of the reference state m_s.
    task automatic model_step();
        int k[4][3];
        int op[3];
        int dx, dy, dz;
        longint sum, inc;
        for (int st = 0; st < 4; st++) begin
            for (int a = 0; a < 3; a++) begin
                case (st)
                    0:       op[a] = m_s[a];
                    1:       op[a] = fit(longint'(m_s[a]) + longint'(k[0][a] >>> (H + 1)));
                    2:       op[a] = fit(longint'(m_s[a]) + longint'(k[1][a] >>> (H + 1)));
                    default: op[a] = fit(longint'(m_s[a]) + longint'(k[2][a] >>> H));
                endcase
            end
            dfun(op[0], op[1], op[2], dx, dy, dz);
            k[st][0] = dx; k[st][1] = dy; k[st][2] = dz;
        end
        for (int a = 0; a < 3; a++) begin
            sum = longint'(k[0][a]) + 2 * longint'(k[1][a]) + 2 * longint'(k[2][a]) + longint'(k[3][a]);
            inc = ((sum >>> H) * 10923) >>> 16;
            m_s[a] = fit(longint'(m_s[a]) + inc);
        end
    endtask

    // Derivative unit: answers after ack_delay waiting cycles, checks operand stability.
    always @(negedge clk) begin
        int dx, dy, dz;
        if (rst) begin
            ack_reg  = 0;
            wait_cnt = 0;
        end else if (deriv_req) begin
            if (wait_cnt > 0) begin
                check("op_x_stable", deriv_x, prev_op[0]);
                check("op_y_stable", deriv_y, prev_op[1]);
                check("op_z_stable", deriv_z, prev_op[2]);
            end
            prev_op[0] = deriv_x; prev_op[1] = deriv_y; prev_op[2] = deriv_z;
            dfun(deriv_x, deriv_y, deriv_z, dx, dy, dz);
            deriv_dx = dx; deriv_dy = dy; deriv_dz = dz;
            if (wait_cnt >= ack_delay) begin
                ack_reg = 1;
                accept_q.push_back(deriv_x);
                n_accept++;
            end else begin
                ack_reg = 0;
            end
            wait_cnt++;
        end else begin
            if (wait_cnt > 0 && !ack_reg)
                check("req_held_until_ack", 32'(deriv_req), 32'd1);
            ack_reg  = 0;
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin
            valid_cnt++;
            $display("commit cyc=%0d step_count=%0d x=%h y=%h z=%h", cyc, step_count, x, y, z);
        end
    end

    task automatic do_reset();
        rst = 1; run = 0; load = 0; max_steps = 0; ack_force = 0; ack_tied = 0; ack_delay = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        m_s[0] = 32'sh00010000; m_s[1] = 0; m_s[2] = 0;
        accept_q.delete();
        n_accept = 0;
    endtask

    task automatic do_load(input int ix, input int iy, input int iz);
        load = 1; init_x = ix; init_y = iy; init_z = iz;
        @(negedge clk);
        load = 0;
        m_s[0] = ix; m_s[1] = iy; m_s[2] = iz;
    endtask

    task automatic wait_valid(input string tag);
        @(negedge clk);
        for (int i = 0; i < 400 && !out_valid; i++) @(negedge clk);
        check({tag, "_commit_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic rand_field();
        const_mode = 0;
        for (int a = 0; a < 3; a++) bias[a] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic check_model(input string tag);
        model_step();
        check({tag, "_x"}, x, m_s[0]);
        check({tag, "_y"}, y, m_s[1]);
        check({tag, "_z"}, z, m_s[2]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, v0, exp_ops[4];
        logic [31:0] got;
        exp_ops = '{32'h00010000, 32'h00010080, 32'h00010080, 32'h00010100};

        // Reset state
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_x", x, 32'h00010000);
        check("rst_y", y, 32'h0);
        check("rst_z", z, 32'h0);
        check("rst_step_count", 32'(step_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_deriv_req", 32'(deriv_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);

        // Constant derivative, ack tied high
        do_reset();
        const_mode = 1; c_d[0] = 32'h00010000; c_d[1] = 32'h00010000; c_d[2] = 32'h00010000;
        ack_tied = 1;
        run = 1;
        wait_valid("const1");
        check("const_x", x, 32'h00010100);
        check("const_y", y, 32'h00000100);
        for (int i = 0; i < 4; i++) begin
            got = (accept_q.size() > i) ? accept_q[i] : 32'hDEADBEEF;
            check($sformatf("const_op%0d", i + 1), got, exp_ops[i]);
        end
        model_step();
        t0 = cyc;
        wait_valid("const2");
        check("const_gap", cyc - t0, 32'd9);
        check_model("const_step2");
        run = 0;
        wait_idle("const");

        // Wait states: ack three cycles after each request
        do_reset();
        const_mode = 1;
        ack_delay = 3;
        run = 1;
        wait_valid("wait1");
        check("wait_x", x, 32'h00010100);
        t0 = cyc;
        wait_valid("wait2");
        check("wait_gap", cyc - t0, 32'd21);
        run = 0;
        wait_idle("wait");

        // Step limit of three with a randomized field and start state
        do_reset();
        rand_field();
        ack_tied = 1;
        do_load(int'($urandom) >>> 6, int'($urandom) >>> 6, int'($urandom) >>> 6);
        check("load_x", x, m_s[0]);
        check("load_step_count", 32'(step_count), 32'd0);
        max_steps = 3;
        run = 1;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            wait_valid($sformatf("lim%0d", i));
            check_model($sformatf("lim_step%0d", i));
        end
        repeat (30) @(negedge clk);
        check("lim_pulses", valid_cnt - v0, 32'd3);
        check("lim_step_count", 32'(step_count), 32'd3);
        check("lim_busy", 32'(busy), 32'd0);
        run = 0;

        // run dropped during REQ2: the step still commits
        do_reset();
        rand_field();
        ack_delay = 2;
        run = 1;
        for (int i = 0; i < 100 && !(n_accept == 1 && deriv_req); i++) @(negedge clk);
        check("drop_reached_req2", 32'(deriv_req), 32'd1);
        run = 0;
        v0 = valid_cnt;
        wait_valid("drop");
        check_model("drop_step");
        repeat (20) @(negedge clk);
        check("drop_pulses", valid_cnt - v0, 32'd1);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_step_count", 32'(step_count), 32'd1);

        // Overflow boundary; load wins over run in the same cycle
        do_reset();
        const_mode = 1; c_d[0] = 32'h7FFF0000; c_d[1] = 0; c_d[2] = 0;
        ack_tied = 1;
        max_steps = 1;
        run = 1;
        do_load(32'sh7FFFFF00, 0, 0);
        check("load_prio_busy", 32'(busy), 32'd0);
        check("load_prio_x", x, 32'h7FFFFF00);
        wait_valid("ovf");
`ifdef LORENZ_SAT_EN
        check("ovf_x", x, 32'h7FFFFFFF);
`else
        check("ovf_x", x, 32'h807FFEFF);
`endif
        check_model("ovf_model");
        wait_idle("ovf");
        check("ovf_step_count", 32'(step_count), 32'd1);
        run = 0;

        // Reset during PREP3, then a stray ack
        do_reset();
        rand_field();
        ack_delay = 1;
        run = 1;
        for (int i = 0; i < 200 && !(n_accept == 3 && !deriv_req && busy); i++) @(negedge clk);
        check("mid_reached_prep3", 32'(n_accept == 3 && !deriv_req && busy), 32'd1);
        rst = 1; run = 0;
        v0 = valid_cnt;
        @(negedge clk);
        rst = 0;
        ack_force = 1;
        @(negedge clk);
        ack_force = 0;
        for (int i = 0; i < 6; i++) begin
            check("mid_deriv_req", 32'(deriv_req), 32'd0);
            @(negedge clk);
        end
        check("mid_x", x, 32'h00010000);
        check("mid_y", y, 32'h0);
        check("mid_z", z, 32'h0);
        check("mid_step_count", 32'(step_count), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_no_valid", valid_cnt - v0, 32'd0);

        // Randomized runs with random ack latency
        for (int t = 0; t < 3; t++) begin
            do_reset();
            rand_field();
            ack_delay = int'($urandom_range(0, 2));
            do_load(int'($urandom) >>> 4, int'($urandom) >>> 4, int'($urandom) >>> 4);
            max_steps = 16'(2 + t);
            run = 1;
            for (int i = 0; i < 2 + t; i++) begin
                wait_valid($sformatf("rnd%0d_%0d", t, i));
                check_model($sformatf("rnd%0d_step%0d", t, i));
            end
            wait_idle($sformatf("rnd%0d", t));
            check($sformatf("rnd%0d_step_count", t), 32'(step_count), 32'(2 + t));
            run = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lorenz_rk4_sequencer.md
LORENZ_RK4_SEQUENCER -- requirements
Module: lorenz_rk4_sequencer

Interface
REQ-001 SHALL have parameter H_SHIFT, default 8, step size h = 2^-H_SHIFT.
REQ-002 SHALL have parameters X0 = 32'h00010000, Y0 = 0, Z0 = 0, the Q16.16 reset state.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 SHALL have these control ports:
- run  in  1: free-run enable.
- max_steps  in  16: step limit; 0 means unlimited.
- load  in  1: load init_* into the state.
- init_x, init_y, init_z  in  32 signed: Q16.16 load values.
REQ-005 SHALL have these derivative-unit ports:
- deriv_req  out  1: evaluation request.
- deriv_x, deriv_y, deriv_z  out  32 signed: operand state.
- deriv_ack  in  1: result valid; completes the request.
- deriv_dx, deriv_dy, deriv_dz  in  32 signed: Q16.16 derivatives.
REQ-006 SHALL have these status ports:
- x, y, z  out  32 signed: committed Q16.16 state.
- out_valid  out  1: 1-cycle pulse on each commit.
- busy  out  1: a step is in progress.
- step_count  out  16: steps committed.

Function
REQ-007 SHALL use states IDLE, REQ(k), PREP(k) for k = 1..4, and UPDATE.
REQ-008 SHALL go IDLE->REQ1 when run=1 in IDLE and (max_steps=0 or step_count<max_steps).
REQ-009 SHALL hold deriv_req=1 and keep deriv_x/y/z stable throughout REQ(k) until deriv_ack=1; a request completes in the same cycle ack is sampled.
REQ-010 SHALL capture deriv_dx/dy/dz as k_k on ack in REQ(k), then go to PREP(k) with deriv_req=0; deriv_req SHALL be low for at least one cycle between requests.
REQ-011 SHALL ignore deriv_ack when deriv_req=0.
REQ-012 SHALL form the operands:
- stage 1 = s.
- stage 2 = s + (k1>>>(H_SHIFT+1)).
- stage 3 = s + (k2>>>(H_SHIFT+1)).
- stage 4 = s + (k3>>>H_SHIFT).
- All shifts arithmetic.
REQ-013 SHALL go PREP(k)->REQ(k+1) for k<4, and PREP4->UPDATE.
REQ-014 SHALL, in UPDATE, compute per axis:
- sum = k1+2k2+2k3+k4, 35-bit signed.
- inc = ((sum>>>H_SHIFT)*10923)>>>16, truncated toward minus infinity.
- s <= s+inc.
REQ-015 SHALL, on the cycle after UPDATE, present the new s on x/y/z, pulse out_valid, and increment step_count.
REQ-016 SHALL, on that cycle, go to REQ1 if run=1 and the limit is not reached; otherwise it SHALL go to IDLE.
REQ-017 SHALL wrap step_count 16'hFFFF->0 when max_steps=0.
REQ-018 SHALL, when run deasserts mid-step, complete the current step, commit it, then go to IDLE.
REQ-019 SHALL honour load only in IDLE: s <= init_*, step_count <= 0, no out_valid; load SHALL be ignored outside IDLE.
REQ-020 SHALL give load priority over run when both are high in IDLE; run is re-evaluated next cycle.
REQ-021 SHALL assert busy=1 in every state except IDLE.
REQ-022 SHALL, with deriv_ack tied high, commit one step every 9 cycles: 4x(REQ+PREP) + UPDATE.

Reset
REQ-023 SHALL, on rst=1, force:
- IDLE state.
- x=X0, y=Y0, z=Z0.
- k registers cleared.
- step_count=0.
- deriv_req, out_valid, busy all 0.
REQ-024 SHALL apply REQ-023 immediately when rst asserts mid-step, discarding the in-flight step; a late deriv_ack after reset SHALL be ignored.

Configuration
REQ-025 SHALL, with LORENZ_SAT_EN defined, saturate every stage-operand add and every state-update add to [32'h80000000, 32'h7FFFFFFF].
REQ-026 SHALL, with LORENZ_SAT_EN undefined, wrap every stage-operand add and every state-update add modulo 2^32.

Verification
REQ-027 SHALL check reset: rst=1 for 3 cycles -> x=32'h00010000, y=0, z=0, step_count=0, and busy, deriv_req, out_valid all 0.
REQ-028 SHALL check constant derivative, ack tied high, deriv_d*=32'h00010000, run=1:
- deriv_x sequence 00010000, 00010080, 00010080, 00010100.
- x=32'h00010100 after the first out_valid.
- out_valid pulses 9 cycles apart.
REQ-029 SHALL check wait states: ack delayed 3 cycles per request -> deriv_req and deriv_x/y/z stable while waiting; out_valid 21 cycles apart; same x result as REQ-028.
REQ-030 SHALL check stopping:
- max_steps=3 -> exactly 3 out_valid pulses, step_count=3, then IDLE with busy=0.
- Separately, run dropped during REQ2 -> that step commits, then IDLE.
REQ-031 SHALL check the overflow boundary: load init_x=32'h7FFFFF00, constant dx=32'h7FFF0000 -> x=32'h7FFFFFFF with LORENZ_SAT_EN, and x=32'h807FFEFF without it.
REQ-032 SHALL check reset mid-operation: rst asserted during PREP3, then deriv_ack pulsed once -> state per REQ-023, no out_valid, deriv_req stays 0.
